counts_readout: RTL and testbench

Snapshot-and-stream readout for the pairwise coincidence counters. On a `Snap` request it captures all `NPAIRS` counts into a shadow bank in a single cycle. It then emits the counts as a framed byte stream over a valid/ready interface, which typically feeds a UART transmitter or a host FIFO. It sits downstream of the coincidence detector and is the only reader of its `Counts` array.

---
 rtl/counts_readout_pkg.sv | 17 +
 rtl/counts_snapshot.sv | 39 +++
 rtl/counts_readout.sv | 161 ++++++++++++++++
 tb/tb_counts_readout.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counts_readout_pkg.sv
// Shared definitions for the coincidence-count readout: frame header, FSM states, byte sizing.
// The CKSUM state exists only when COUNTS_READOUT_CKSUM_EN is defined.
package counts_readout_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

`ifdef COUNTS_READOUT_CKSUM_EN
  typedef enum logic [2:0] {IDLE, HEADER, SEQ, DATA, CKSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, HEADER, SEQ, DATA} state_t;
`endif

  function automatic int bytes_per_count(input int nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/counts_snapshot.sv
// Shadow bank of detector counts, loaded in one cycle and read back one byte at a time.
// ByteSel 0 selects the most significant byte of the zero-extended count.
module counts_snapshot
  import counts_readout_pkg::*;
#(
  parameter int NBITS  = 6,
  parameter int NPAIRS = 10,
  parameter int PAIRW  = $clog2(NPAIRS + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [NBITS-1:0] CountsIn [NPAIRS],
  input  logic [PAIRW-1:0] Pair,
  input  logic             ByteSel,
  output logic [7:0]       ByteOut
);

  localparam int BPC = bytes_per_count(NBITS);

  logic [NBITS-1:0] bank [NPAIRS];
  logic [15:0]      wide;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NPAIRS; i++) bank[i] <= '0;
    end else if (Load) begin
      bank <= CountsIn;
    end
  end

  // Pair may point one past the end once the last byte is loaded; read zero there.
  always_comb begin
    wide = '0;
    if (Pair < PAIRW'(NPAIRS)) wide = 16'(bank[Pair]);
    ByteOut = ByteSel ? wide[7:0] : wide[8*BPC-1 -: 8];
  end

endmodule

// File: rtl/counts_readout.sv
// Snapshot-and-stream readout: captures all pair counts on Snap and sends them as a framed byte stream.
// Define COUNTS_READOUT_CKSUM_EN to append an XOR checksum byte to every frame.
module counts_readout
  import counts_readout_pkg::*;
#(
  parameter int  NCHAN  = 5,
  parameter int  NBITS  = 6,
  localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [NBITS-1:0] Counts [NPAIRS],
  input  logic             Snap,
  output logic [7:0]       TxData,
  output logic             TxValid,
  input  logic             TxReady,
  output logic             Busy,
  output logic             Done,
  output logic             Overrun
);

  localparam int BPC   = bytes_per_count(NBITS);
  localparam int PAIRW = $clog2(NPAIRS + 1);

  state_t           state;
  logic [7:0]       seq;
  logic [PAIRW-1:0] rd_pair;
  logic             rd_byte;
  logic [PAIRW-1:0] adv_pair;
  logic             adv_byte;
  logic [7:0]       snap_byte;
  logic             load;
  logic             hs;
  logic             data_end;

  assign load     = (state == IDLE) && Snap;
  assign hs       = TxValid && TxReady;
  assign data_end = (rd_pair == PAIRW'(NPAIRS));

  counts_snapshot #(
    .NBITS (NBITS),
    .NPAIRS(NPAIRS),
    .PAIRW (PAIRW)
  ) u_snapshot (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Load    (load),
    .CountsIn(Counts),
    .Pair    (rd_pair),
    .ByteSel (rd_byte),
    .ByteOut (snap_byte)
  );

  // Read pointer always names the next byte to be placed on TxData.
  always_comb begin
    adv_pair = rd_pair;
    adv_byte = 1'b0;
    if (BPC == 1 || rd_byte) adv_pair = rd_pair + 1'b1;
    else adv_byte = 1'b1;
  end

`ifdef COUNTS_READOUT_CKSUM_EN
  logic [7:0] cksum;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cksum <= 8'h00;
    end else if (load) begin
      cksum <= FRAME_HDR;
    end else if (hs) begin
      case (state)
        HEADER:  cksum <= cksum ^ seq;
        SEQ:     cksum <= cksum ^ snap_byte;
        DATA:    if (!data_end) cksum <= cksum ^ snap_byte;
        default: cksum <= cksum;
      endcase
    end
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      TxData  <= 8'h00;
      TxValid <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Overrun <= 1'b0;
      seq     <= 8'h00;
      rd_pair <= '0;
      rd_byte <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Snap && state != IDLE) Overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (Snap) begin
            state   <= HEADER;
            TxData  <= FRAME_HDR;
            TxValid <= 1'b1;
            Busy    <= 1'b1;
            Overrun <= 1'b0;
            rd_pair <= '0;
            rd_byte <= 1'b0;
          end
        end
        HEADER: begin
          if (hs) begin
            state  <= SEQ;
            TxData <= seq;
          end
        end
        SEQ: begin
          if (hs) begin
            state   <= DATA;
            TxData  <= snap_byte;
            rd_pair <= adv_pair;
            rd_byte <= adv_byte;
          end
        end
        DATA: begin
          if (hs) begin
            if (!data_end) begin
              TxData  <= snap_byte;
              rd_pair <= adv_pair;
              rd_byte <= adv_byte;
            end else begin
`ifdef COUNTS_READOUT_CKSUM_EN
              state  <= CKSUM;
              TxData <= cksum;
`else
              state   <= IDLE;
              TxValid <= 1'b0;
              Busy    <= 1'b0;
              Done    <= 1'b1;
              seq     <= seq + 8'h01;
`endif
            end
          end
        end
`ifdef COUNTS_READOUT_CKSUM_EN
        CKSUM: begin
          if (hs) begin
            state   <= IDLE;
            TxValid <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            seq     <= seq + 8'h01;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          TxValid <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counts_readout.sv
// Scoreboard bench for counts_readout: a frame model fills expected-byte queues, monitors drain them.
// Two instances: default 6-bit counts and 12-bit counts (two bytes per count).
module tb_counts_readout;

  localparam int NP = 10;

  typedef logic [7:0] byteQ_t [$];
  typedef struct {
    logic [7:0] data;
    bit         last;
    int         frameLen;
  } expByte_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        snap6, snap12, ready6, ready12;
  logic [5:0]  counts6  [NP];
  logic [11:0] counts12 [NP];
  logic [7:0]  txData6, txData12;
  logic        txValid6, txValid12, busy6, busy12, done6, done12, overrun6, overrun12;

  int       checks = 0;
  int       failures = 0;
  bit       randReady = 1'b0;
  int       seq6 = 0;
  int       seq12 = 0;
  expByte_t exp6[$];
  expByte_t exp12[$];

  // Monitor state
  expByte_t   e6, e12;
  bit         doneDue6 = 0, doneDue12 = 0, stallPrev6 = 0;
  int         dueLen6 = 0, busyCnt6 = 0, stallCnt6 = 0;
  logic [7:0] heldData6 = 8'h00;

  always #5 clk = ~clk;

  counts_readout u_dut6 (
    .Clk(clk), .Rst_n(rstN), .Counts(counts6), .Snap(snap6),
    .TxData(txData6), .TxValid(txValid6), .TxReady(ready6),
    .Busy(busy6), .Done(done6), .Overrun(overrun6)
  );

  counts_readout #(.NBITS(12)) u_dut12 (
    .Clk(clk), .Rst_n(rstN), .Counts(counts12), .Snap(snap12),
    .TxData(txData12), .TxValid(txValid12), .TxReady(ready12),
    .Busy(busy12), .Done(done12), .Overrun(overrun12)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference frame: header, sequence, each count big-endian over whole bytes, optional XOR of all.
  function automatic byteQ_t buildFrame(input int vals[NP], input int nbits, input int seqv);
    byteQ_t     q;
    logic [7:0] x;
    int         bpc;
    bpc = (nbits + 7) / 8;
    q.push_back(8'hA5);
    q.push_back(8'(seqv % 256));
    for (int p = 0; p < NP; p++)
      for (int b = bpc - 1; b >= 0; b--)
        q.push_back(8'((vals[p] >> (8 * b)) % 256));
`ifdef COUNTS_READOUT_CKSUM_EN
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`endif
    return q;
  endfunction

  task automatic applyStimulus(input bit wide, input int vals[NP]);
    byteQ_t q;
    @(posedge clk); #1;
    if (wide) begin
      foreach (vals[p]) counts12[p] = 12'(vals[p]);
      q = buildFrame(vals, 12, seq12);
      foreach (q[i]) exp12.push_back('{q[i], i == q.size() - 1, q.size()});
      snap12 = 1'b1;
    end else begin
      foreach (vals[p]) counts6[p] = 6'(vals[p]);
      q = buildFrame(vals, 6, seq6);
      foreach (q[i]) exp6.push_back('{q[i], i == q.size() - 1, q.size()});
      snap6 = 1'b1;
    end
    @(posedge clk); #1;
    snap6  = 1'b0;
    snap12 = 1'b0;
  endtask

  task automatic waitDone(input bit wide, input int budget);
    int n = 0;
    while ((wide ? done12 : done6) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(wide ? "frame_done12" : "frame_done6", wide ? done12 : done6, 1);
    if (wide) seq12 = (seq12 + 1) % 256;
    else seq6 = (seq6 + 1) % 256;
  endtask

  task automatic randomFrame6();
    int vals[NP];
    foreach (vals[p]) vals[p] = int'($urandom_range(0, 63));
    applyStimulus(1'b0, vals);
    waitDone(1'b0, 400);
  endtask

  // Random backpressure on the 6-bit instance
  initial begin
    forever begin
      @(posedge clk); #1;
      ready6 = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rstN) begin
      doneDue6   = 0;
      stallPrev6 = 0;
      busyCnt6   = 0;
      stallCnt6  = 0;
    end else begin
      checkOutput("done6", done6, doneDue6);
      if (doneDue6) begin
        checkOutput("idle_after_done6", {busy6, txValid6}, 0);
        checkOutput("frame_len6", busyCnt6, dueLen6 + stallCnt6);
        busyCnt6  = 0;
        stallCnt6 = 0;
      end
      doneDue6 = 0;
      if (stallPrev6) begin
        checkOutput("stall_valid6", txValid6, 1);
        checkOutput("stall_data6", txData6, heldData6);
      end
      if (busy6) busyCnt6++;
      if (txValid6 && !ready6) stallCnt6++;
      stallPrev6 = txValid6 && !ready6;
      heldData6  = txData6;
      if (txValid6 && ready6) begin
        checkOutput("pending6", exp6.size() != 0, 1);
        if (exp6.size() != 0) begin
          e6 = exp6.pop_front();
          checkOutput("byte6", txData6, e6.data);
          doneDue6 = e6.last;
          dueLen6  = e6.frameLen;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rstN) begin
      doneDue12 = 0;
    end else begin
      checkOutput("done12", done12, doneDue12);
      doneDue12 = 0;
      if (txValid12 && ready12) begin
        checkOutput("pending12", exp12.size() != 0, 1);
        if (exp12.size() != 0) begin
          e12 = exp12.pop_front();
          checkOutput("byte12", txData12, e12.data);
          doneDue12 = e12.last;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vals[NP];
    rstN    = 1'b0;
    snap6   = 1'b0;
    snap12  = 1'b0;
    ready6  = 1'b1;
    ready12 = 1'b1;
    foreach (counts6[p]) counts6[p] = '0;
    foreach (counts12[p]) counts12[p] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_txdata", txData6, 8'h00);
    checkOutput("rst_txvalid", txValid6, 0);
    checkOutput("rst_busy", busy6, 0);
    checkOutput("rst_done", done6, 0);
    checkOutput("rst_overrun", overrun6, 0);
    rstN = 1'b1;

    $display("[TB] basic frame");
    foreach (vals[p]) vals[p] = p + 1;
    applyStimulus(1'b0, vals);
    checkOutput("first_txdata", txData6, 8'hA5);
    checkOutput("first_txvalid", txValid6, 1);
    checkOutput("first_busy", busy6, 1);
    waitDone(1'b0, 100);

    $display("[TB] backpressure");
    randReady = 1'b1;
    for (int f = 0; f < 6; f++) randomFrame6();
    randReady = 1'b0;
    @(posedge clk); #2;

    $display("[TB] snapshot isolation and overrun");
    foreach (vals[p]) vals[p] = 63 - p;
    applyStimulus(1'b0, vals);
    repeat (3) @(posedge clk);
    #1;
    foreach (counts6[p]) counts6[p] = 6'(p * 5);
    snap6 = 1'b1;
    @(posedge clk); #1;
    snap6 = 1'b0;
    waitDone(1'b0, 100);
    checkOutput("overrun_set", overrun6, 1);
    foreach (vals[p]) vals[p] = p * 5;
    applyStimulus(1'b0, vals);
    checkOutput("overrun_clear", overrun6, 0);
    waitDone(1'b0, 100);

    $display("[TB] two-byte counts");
    foreach (vals[p]) vals[p] = int'($urandom_range(0, 4095));
    vals[0] = 12'hABC;
    applyStimulus(1'b1, vals);
    waitDone(1'b1, 100);

    $display("[TB] reset mid-frame");
    randomFrame6();
    foreach (vals[p]) vals[p] = int'($urandom_range(0, 63));
    applyStimulus(1'b0, vals);
    repeat (4) @(posedge clk);
    #1;
    rstN = 1'b0;
    exp6.delete();
    #1;
    checkOutput("abort_txvalid", txValid6, 0);
    checkOutput("abort_busy", busy6, 0);
    checkOutput("abort_txdata", txData6, 8'h00);
    @(posedge clk); #1;
    rstN  = 1'b1;
    seq6  = 0;
    seq12 = 0;

    $display("[TB] sequence wrap");
    for (int f = 0; f < 257; f++) randomFrame6();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain6", exp6.size(), 0);
    checkOutput("drain12", exp12.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
